// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of a single SDRAM controller host port.
// One transaction at a time: IDLE selects a winner, BUSY waits for completion, DONE spaces out re-grants.
module sdram_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [15:0] p0_wdata,
    input  logic        p0_wr_en,
    input  logic [1:0]  p0_bytesel,
    output logic [15:0] p0_rdata,
    output logic        p0_ack,

    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [15:0] p1_wdata,
    input  logic        p1_wr_en,
    input  logic [1:0]  p1_bytesel,
    output logic [15:0] p1_rdata,
    output logic        p1_ack,

    output logic [31:0] m_addr,
    output logic [15:0] m_wdata,
    output logic        m_wr_en,
    output logic [1:0]  m_bytesel,
    input  logic [15:0] m_rdata,
    input  logic        m_compl,
    input  logic        m_config_done,

    output logic [1:0]  grant,
    output logic [1:0]  state_o
);

    // Handshake: a port raises req with addr/wdata/wr_en/bytesel stable and holds them
    // until its ack pulses for one cycle; a dropped req never cancels a granted access.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;
    logic        zero_q, zero_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [15:0] m_wdata_q, m_wdata_d;
    logic        m_wr_en_q, m_wr_en_d;
    logic [1:0]  m_bytesel_q, m_bytesel_d;
    logic [15:0] p0_rdata_q, p0_rdata_d;
    logic [15:0] p1_rdata_q, p1_rdata_d;
    logic [1:0]  ack_q, ack_d;

    logic        sel_p1;
    logic [1:0]  win_bytesel;
    logic        win_wr_en;

    // last_q holds the index of the most recently granted port.
    always_comb begin
        sel_p1 = 1'b0;
        if (FIXED_PRIO != 0) begin
            sel_p1 = !p0_req;
        end else begin
            sel_p1 = p1_req && (!p0_req || !last_q);
        end
        win_bytesel = sel_p1 ? p1_bytesel : p0_bytesel;
        win_wr_en   = sel_p1 ? p1_wr_en   : p0_wr_en;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        zero_d      = zero_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_wr_en_d   = m_wr_en_q;
        m_bytesel_d = m_bytesel_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        ack_d       = 2'b00;

        case (state_q)
            IDLE: begin
                if (m_config_done && (p0_req || p1_req)) begin
                    grant_d     = sel_p1 ? 2'b10 : 2'b01;
                    last_d      = sel_p1;
                    m_addr_d    = sel_p1 ? p1_addr  : p0_addr;
                    m_wdata_d   = sel_p1 ? p1_wdata : p0_wdata;
                    m_bytesel_d = win_bytesel;
                    m_wr_en_d   = (win_bytesel != 2'b00) && win_wr_en;
                    zero_d      = (win_bytesel == 2'b00);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // An empty byte select never reaches the controller, so complete it locally.
                if (zero_q || m_compl) begin
                    if (!zero_q && !m_wr_en_q) begin
                        if (grant_q[0]) p0_rdata_d = m_rdata;
                        if (grant_q[1]) p1_rdata_d = m_rdata;
                    end
                    ack_d       = grant_q;
                    m_bytesel_d = 2'b00;
                    m_wr_en_d   = 1'b0;
                    grant_d     = 2'b00;
                    zero_d      = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            zero_q      <= 1'b0;
            m_addr_q    <= 32'd0;
            m_wdata_q   <= 16'd0;
            m_wr_en_q   <= 1'b0;
            m_bytesel_q <= 2'b00;
            p0_rdata_q  <= 16'd0;
            p1_rdata_q  <= 16'd0;
            ack_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            zero_q      <= zero_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_wr_en_q   <= m_wr_en_d;
            m_bytesel_q <= m_bytesel_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            ack_q       <= ack_d;
        end
    end

    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_ack    = ack_q[0];
    assign p1_ack    = ack_q[1];
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wr_en   = m_wr_en_q;
    assign m_bytesel = m_bytesel_q;
    assign grant     = grant_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a round-robin and a fixed-priority instance share all inputs.
module tb_sdram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p1_req;
    logic [31:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_wr_en, p1_wr_en;
    logic [1:0]  p0_bytesel, p1_bytesel;
    logic [15:0] m_rdata;
    logic        m_compl;
    logic        m_config_done;

    logic [15:0] p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack;
    logic [31:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_wr_en;
    logic [1:0]  m_bytesel;
    logic [1:0]  grant;
    logic [1:0]  state;

    logic [15:0] f_p0_rdata, f_p1_rdata;
    logic        f_p0_ack, f_p1_ack;
    logic [31:0] f_m_addr;
    logic [15:0] f_m_wdata;
    logic        f_m_wr_en;
    logic [1:0]  f_m_bytesel;
    logic [1:0]  f_grant;
    logic [1:0]  f_state;

    int checks;
    int failures;
    logic [15:0] exp_p0, exp_p1, exp_f_p0;

    sdram_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wr_en(p0_wr_en),
        .p0_bytesel(p0_bytesel), .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wr_en(p1_wr_en),
        .p1_bytesel(p1_bytesel), .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel),
        .m_rdata(m_rdata), .m_compl(m_compl), .m_config_done(m_config_done),
        .grant(grant), .state_o(state)
    );

    sdram_arbiter #(.FIXED_PRIO(1)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wr_en(p0_wr_en),
        .p0_bytesel(p0_bytesel), .p0_rdata(f_p0_rdata), .p0_ack(f_p0_ack),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wr_en(p1_wr_en),
        .p1_bytesel(p1_bytesel), .p1_rdata(f_p1_rdata), .p1_ack(f_p1_ack),
        .m_addr(f_m_addr), .m_wdata(f_m_wdata), .m_wr_en(f_m_wr_en), .m_bytesel(f_m_bytesel),
        .m_rdata(m_rdata), .m_compl(m_compl), .m_config_done(m_config_done),
        .grant(f_grant), .state_o(f_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; m_config_done = 1'b0; m_compl = 1'b0; m_rdata = 16'h0;
        p0_req = 1'b0; p0_addr = 32'h0; p0_wdata = 16'h0; p0_wr_en = 1'b0; p0_bytesel = 2'b00;
        p1_req = 1'b0; p1_addr = 32'h0; p1_wdata = 16'h0; p1_wr_en = 1'b0; p1_bytesel = 2'b00;
        tick; tick;
        checks++;
        if ({m_addr, m_wdata, m_wr_en, m_bytesel, grant, p0_ack, p1_ack, p0_rdata, p1_rdata, state} !== '0) begin
            failures++;
            $display("FAIL reset_rr actual=%h required=0",
                     {m_addr, m_wdata, m_wr_en, m_bytesel, grant, p0_ack, p1_ack, p0_rdata, p1_rdata, state});
        end
        checks++;
        if ({f_m_addr, f_m_wdata, f_m_wr_en, f_m_bytesel, f_grant, f_p0_ack, f_p1_ack, f_p0_rdata, f_p1_rdata, f_state} !== '0) begin
            failures++;
            $display("FAIL reset_fx actual=%h required=0",
                     {f_m_addr, f_m_wdata, f_m_wr_en, f_m_bytesel, f_grant, f_p0_ack, f_p1_ack, f_p0_rdata, f_p1_rdata, f_state});
        end
        rst_n = 1'b1;
        tick;
        exp_p0 = 16'h0; exp_p1 = 16'h0; exp_f_p0 = 16'h0;
    endtask

    task automatic test_config_gating;
        int bad;
        bad = 0;
        p0_addr = 32'h0000_0040; p0_bytesel = 2'b11; p0_wr_en = 1'b0; p0_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (m_bytesel !== 2'b00 || grant !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL cfg_gate_idle active_cycles=%0d required=0", bad);
        end
        m_config_done = 1'b1;
        tick;
        checks++;
        if (grant !== 2'b01 || f_grant !== 2'b01) begin
            failures++;
            $display("FAIL cfg_first_grant rr=%b fx=%b required=01", grant, f_grant);
        end
        checks++;
        if (m_addr !== 32'h0000_0040 || m_bytesel !== 2'b11) begin
            failures++;
            $display("FAIL cfg_m_regs addr=%h bytesel=%b required=00000040/11", m_addr, m_bytesel);
        end
        // Requester drops req while granted: the access must still complete.
        p0_req = 1'b0;
        tick;
        checks++;
        if (grant !== 2'b01 || m_bytesel !== 2'b11 || p0_ack !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold grant=%b bytesel=%b ack=%b required=01/11/0", grant, m_bytesel, p0_ack);
        end
        m_compl = 1'b1; m_rdata = 16'h1111;
        tick;
        m_compl = 1'b0;
        exp_p0 = 16'h1111; exp_f_p0 = 16'h1111;
        checks++;
        if (p0_ack !== 1'b1 || p0_rdata !== exp_p0 || grant !== 2'b00 || m_bytesel !== 2'b00) begin
            failures++;
            $display("FAIL abort_ack ack=%b rdata=%h grant=%b bytesel=%b required=1/%h/00/00",
                     p0_ack, p0_rdata, grant, m_bytesel, exp_p0);
        end
        tick;
        checks++;
        if (p0_ack !== 1'b0) begin
            failures++;
            $display("FAIL abort_ack_width ack=%b required=0", p0_ack);
        end
    endtask

    task automatic test_read;
        int bad;
        bad = 0;
        p0_addr = 32'h0000_0100; p0_bytesel = 2'b11; p0_wr_en = 1'b0; p0_wdata = 16'h0; p0_req = 1'b1;
        tick;
        checks++;
        if (grant !== 2'b01 || m_addr !== 32'h0000_0100 || m_wr_en !== 1'b0 || m_bytesel !== 2'b11) begin
            failures++;
            $display("FAIL read_issue grant=%b addr=%h wr_en=%b bytesel=%b required=01/00000100/0/11",
                     grant, m_addr, m_wr_en, m_bytesel);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            if (m_addr !== 32'h0000_0100 || m_bytesel !== 2'b11 || grant !== 2'b01 || p0_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL read_busy_hold bad_cycles=%0d required=0", bad);
        end
        m_compl = 1'b1; m_rdata = 16'hBEEF;
        tick;
        m_compl = 1'b0; m_rdata = 16'h0;
        exp_p0 = 16'hBEEF; exp_f_p0 = 16'hBEEF;
        checks++;
        if (p0_ack !== 1'b1 || p0_rdata !== exp_p0 || m_bytesel !== 2'b00 || p1_ack !== 1'b0) begin
            failures++;
            $display("FAIL read_done ack=%b rdata=%h bytesel=%b p1_ack=%b required=1/%h/00/0",
                     p0_ack, p0_rdata, m_bytesel, p1_ack, exp_p0);
        end
        checks++;
        if (p1_rdata !== exp_p1 || f_p0_rdata !== exp_f_p0) begin
            failures++;
            $display("FAIL read_other p1_rdata=%h fx_p0_rdata=%h required=%h/%h", p1_rdata, f_p0_rdata, exp_p1, exp_f_p0);
        end
        p0_req = 1'b0;
        tick;
        checks++;
        if (p0_ack !== 1'b0 || p0_rdata !== exp_p0) begin
            failures++;
            $display("FAIL read_single_ack ack=%b rdata=%h required=0/%h", p0_ack, p0_rdata, exp_p0);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        exp_p0 = 16'h0; exp_p1 = 16'h0; exp_f_p0 = 16'h0;
        p0_addr = 32'h0000_1000; p0_bytesel = 2'b11; p0_wr_en = 1'b0;
        p1_addr = 32'h0000_2000; p1_wdata = 16'h5A5A; p1_bytesel = 2'b11; p1_wr_en = 1'b1;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick;
            checks++;
            if (grant !== exp_g || f_grant !== 2'b01) begin
                failures++;
                $display("FAIL rr_grant k=%0d rr=%b fx=%b required=%b/01", k, grant, f_grant, exp_g);
            end
            checks++;
            if (exp_g == 2'b10) begin
                if (m_wr_en !== 1'b1 || m_addr !== 32'h0000_2000 || m_wdata !== 16'h5A5A) begin
                    failures++;
                    $display("FAIL rr_write_regs k=%0d wr_en=%b addr=%h wdata=%h required=1/00002000/5a5a",
                             k, m_wr_en, m_addr, m_wdata);
                end
            end else begin
                if (m_wr_en !== 1'b0 || m_addr !== 32'h0000_1000) begin
                    failures++;
                    $display("FAIL rr_read_regs k=%0d wr_en=%b addr=%h required=0/00001000", k, m_wr_en, m_addr);
                end
            end
            m_compl = 1'b1; m_rdata = 16'hA000 | 16'(k);
            if (exp_g == 2'b01) exp_p0 = m_rdata;
            exp_f_p0 = m_rdata;
            tick;
            m_compl = 1'b0;
            checks++;
            if ({p1_ack, p0_ack} !== exp_g || p0_rdata !== exp_p0 || p1_rdata !== exp_p1) begin
                failures++;
                $display("FAIL rr_ack k=%0d acks=%b p0_rdata=%h p1_rdata=%h required=%b/%h/%h",
                         k, {p1_ack, p0_ack}, p0_rdata, p1_rdata, exp_g, exp_p0, exp_p1);
            end
            checks++;
            if ({f_p1_ack, f_p0_ack} !== 2'b01 || f_p0_rdata !== exp_f_p0) begin
                failures++;
                $display("FAIL fx_ack k=%0d acks=%b rdata=%h required=01/%h", k, {f_p1_ack, f_p0_ack}, f_p0_rdata, exp_f_p0);
            end
            tick;
            checks++;
            if (grant !== 2'b00 || f_grant !== 2'b00 || {p1_ack, p0_ack} !== 2'b00) begin
                failures++;
                $display("FAIL done_ignores_req k=%0d rr=%b fx=%b acks=%b required=00/00/00",
                         k, grant, f_grant, {p1_ack, p0_ack});
            end
            if (k == 3) begin
                p0_req = 1'b0; p1_req = 1'b0;
            end
        end
    endtask

    task automatic test_write_stray;
        p1_addr = 32'h0000_0200; p1_wdata = 16'h1234; p1_bytesel = 2'b01; p1_wr_en = 1'b1; p1_req = 1'b1;
        tick;
        checks++;
        if (grant !== 2'b10 || m_wr_en !== 1'b1 || m_wdata !== 16'h1234 || m_bytesel !== 2'b01 || m_addr !== 32'h0000_0200) begin
            failures++;
            $display("FAIL wr_issue grant=%b wr_en=%b wdata=%h bytesel=%b addr=%h required=10/1/1234/01/00000200",
                     grant, m_wr_en, m_wdata, m_bytesel, m_addr);
        end
        tick;
        checks++;
        if (m_wr_en !== 1'b1) begin
            failures++;
            $display("FAIL wr_busy_wr_en actual=%b required=1", m_wr_en);
        end
        m_compl = 1'b1; m_rdata = 16'hCAFE;
        tick;
        m_compl = 1'b0;
        checks++;
        if (p1_ack !== 1'b1 || p0_ack !== 1'b0 || m_wr_en !== 1'b0 || p1_rdata !== exp_p1) begin
            failures++;
            $display("FAIL wr_done p1_ack=%b p0_ack=%b wr_en=%b p1_rdata=%h required=1/0/0/%h",
                     p1_ack, p0_ack, m_wr_en, p1_rdata, exp_p1);
        end
        p1_req = 1'b0;
        tick;
        checks++;
        if ({p1_ack, p0_ack} !== 2'b00 || m_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL wr_after acks=%b wr_en=%b required=00/0", {p1_ack, p0_ack}, m_wr_en);
        end
        m_compl = 1'b1; m_rdata = 16'hDEAD;
        tick;
        m_compl = 1'b0;
        checks++;
        if ({p1_ack, p0_ack} !== 2'b00 || grant !== 2'b00) begin
            failures++;
            $display("FAIL stray_idle_ack acks=%b grant=%b required=00/00", {p1_ack, p0_ack}, grant);
        end
        tick;
        checks++;
        if ({p1_ack, p0_ack} !== 2'b00 || p0_rdata !== exp_p0 || p1_rdata !== exp_p1) begin
            failures++;
            $display("FAIL stray_idle_rdata acks=%b p0=%h p1=%h required=00/%h/%h",
                     {p1_ack, p0_ack}, p0_rdata, p1_rdata, exp_p0, exp_p1);
        end
    endtask

    task automatic test_zero_bytesel;
        p0_addr = 32'h0000_0300; p0_bytesel = 2'b00; p0_wr_en = 1'b1; p0_req = 1'b1;
        tick;
        checks++;
        if (grant !== 2'b01 || m_bytesel !== 2'b00 || m_wr_en !== 1'b0 || p0_ack !== 1'b0) begin
            failures++;
            $display("FAIL zero_grant grant=%b bytesel=%b wr_en=%b ack=%b required=01/00/0/0",
                     grant, m_bytesel, m_wr_en, p0_ack);
        end
        tick;
        checks++;
        if (p0_ack !== 1'b1 || p0_rdata !== exp_p0 || m_bytesel !== 2'b00 || grant !== 2'b00) begin
            failures++;
            $display("FAIL zero_ack ack=%b rdata=%h bytesel=%b grant=%b required=1/%h/00/00",
                     p0_ack, p0_rdata, m_bytesel, grant, exp_p0);
        end
        // Completion pulse while in DONE must be ignored.
        m_compl = 1'b1; m_rdata = 16'h5555; p0_req = 1'b0;
        tick;
        m_compl = 1'b0;
        checks++;
        if ({p1_ack, p0_ack} !== 2'b00 || p0_rdata !== exp_p0) begin
            failures++;
            $display("FAIL stray_done acks=%b rdata=%h required=00/%h", {p1_ack, p0_ack}, p0_rdata, exp_p0);
        end
        tick;
        checks++;
        if ({p1_ack, p0_ack} !== 2'b00 || p0_rdata !== exp_p0) begin
            failures++;
            $display("FAIL stray_done_late acks=%b rdata=%h required=00/%h", {p1_ack, p0_ack}, p0_rdata, exp_p0);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        bad = 0;
        p1_addr = 32'h0000_0400; p1_wdata = 16'h7777; p1_bytesel = 2'b11; p1_wr_en = 1'b1; p1_req = 1'b1;
        tick;
        checks++;
        if (grant !== 2'b10 || m_bytesel !== 2'b11 || m_wr_en !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_issue grant=%b bytesel=%b wr_en=%b required=10/11/1", grant, m_bytesel, m_wr_en);
        end
        #2;
        rst_n = 1'b0; m_config_done = 1'b0;
        #1;
        exp_p0 = 16'h0; exp_p1 = 16'h0;
        checks++;
        if ({m_addr, m_wdata, m_wr_en, m_bytesel, grant, p0_ack, p1_ack, p0_rdata, p1_rdata, state} !== '0) begin
            failures++;
            $display("FAIL rstmid_async_rr actual=%h required=0",
                     {m_addr, m_wdata, m_wr_en, m_bytesel, grant, p0_ack, p1_ack, p0_rdata, p1_rdata, state});
        end
        checks++;
        if ({f_m_addr, f_m_wdata, f_m_wr_en, f_m_bytesel, f_grant, f_p0_ack, f_p1_ack, f_p0_rdata, f_p1_rdata, f_state} !== '0) begin
            failures++;
            $display("FAIL rstmid_async_fx actual=%h required=0",
                     {f_m_addr, f_m_wdata, f_m_wr_en, f_m_bytesel, f_grant, f_p0_ack, f_p1_ack, f_p0_rdata, f_p1_rdata, f_state});
        end
        m_compl = 1'b1;
        tick;
        m_compl = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (grant !== 2'b00 || m_bytesel !== 2'b00 || {p1_ack, p0_ack} !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rstmid_wait_cfg bad_cycles=%0d required=0", bad);
        end
        m_config_done = 1'b1;
        tick;
        checks++;
        if (grant !== 2'b10 || m_bytesel !== 2'b11 || m_addr !== 32'h0000_0400) begin
            failures++;
            $display("FAIL rstmid_regrant grant=%b bytesel=%b addr=%h required=10/11/00000400", grant, m_bytesel, m_addr);
        end
        m_compl = 1'b1; m_rdata = 16'h9999;
        tick;
        m_compl = 1'b0;
        checks++;
        if (p1_ack !== 1'b1 || p0_ack !== 1'b0 || p1_rdata !== exp_p1) begin
            failures++;
            $display("FAIL rstmid_done p1_ack=%b p0_ack=%b p1_rdata=%h required=1/0/%h", p1_ack, p0_ack, p1_rdata, exp_p1);
        end
        p1_req = 1'b0;
        tick;
        checks++;
        if ({p1_ack, p0_ack} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_ack_width acks=%b required=00", {p1_ack, p0_ack});
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_config_gating;
        test_read;
        test_round_robin;
        test_write_stray;
        test_zero_bytesel;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin arbitration and 1 = port 0 always wins.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 p0_req / p1_req  input  1  per-port request level.
REQ-005 p0_addr / p1_addr  input  32  byte address; must be held stable while req=1 until ack.
REQ-006 p0_wdata / p1_wdata  input  16  write data; must be held stable while req=1 until ack.
REQ-007 p0_wr_en / p1_wr_en  input  1  1 = write, 0 = read; must be held stable while req=1 until ack.
REQ-008 p0_bytesel / p1_bytesel  input  2  byte enables; must be held stable while req=1 until ack.
REQ-009 p0_rdata / p1_rdata  output  16  registered read data for the port.
REQ-010 p0_ack / p1_ack  output  1  one-cycle completion pulse for the port.
REQ-011 m_addr  output  32  registered address to the SDRAM controller host port.
REQ-012 m_wdata  output  16  registered write data to the controller.
REQ-013 m_wr_en  output  1  registered write enable to the controller.
REQ-014 m_bytesel  output  2  registered byte select; non-zero starts a controller access.
REQ-015 m_rdata  input  16  read data from the controller.
REQ-016 m_compl  input  1  controller one-cycle completion pulse.
REQ-017 m_config_done  input  1  controller initialisation complete.
REQ-018 grant  output  2  one-hot owner of the current transaction; 00 when none.

Function
REQ-019 States SHALL be IDLE, BUSY and DONE.
REQ-020 In IDLE with m_config_done=0, no request SHALL be granted.
REQ-021 In IDLE with m_config_done=1 and any req=1, the block SHALL select a winner and take these actions on that edge:
- set grant;
- register the winner's addr, wdata, wr_en and bytesel onto m_*;
- move to BUSY.
REQ-022 With one requester, that port SHALL win.
REQ-023 On simultaneous requests with FIXED_PRIO=0, the port not granted last SHALL win.
REQ-024 The last-granted pointer SHALL update on every grant and reset to port 1, so port 0 wins the first tie.
REQ-025 With FIXED_PRIO=1, port 0 SHALL win every tie.
REQ-026 If the winner's bytesel=00, the block SHALL leave m_bytesel=00 and m_wr_en=0, SHALL issue no controller access, SHALL pulse the winner's ack on the next cycle with rdata unchanged, and SHALL go to DONE.
REQ-027 In BUSY, m_* SHALL hold constant until m_compl=1.
REQ-028 On the edge where m_compl=1 in BUSY, the block SHALL take these actions:
- register m_rdata into the granted port's rdata, for reads only;
- assert that port's ack for exactly one cycle;
- set m_bytesel=00 and m_wr_en=0;
- clear grant;
- go to DONE.
REQ-029 Read latency SHALL be one cycle from m_compl to ack with valid rdata.
REQ-030 DONE SHALL last exactly one cycle, SHALL ignore all req inputs, and SHALL return to IDLE; this prevents a still-asserted req in the ack cycle from being re-granted.
REQ-031 A requester MAY present a new request in the cycle after ack; it SHALL be arbitrated in IDLE with other pending requests.
REQ-032 m_compl in IDLE or DONE SHALL be ignored, with no ack and no rdata change; this covers the controller's mode-register completion pulse.
REQ-033 m_wr_en SHALL be 1 only while a granted write is in BUSY, so the controller never drives its data bus outside a write.
REQ-034 The non-granted port's rdata SHALL never change.
REQ-035 At most one ack SHALL be asserted in any cycle.
REQ-036 A port deasserting req while granted SHALL NOT abort the transaction; its ack SHALL still pulse.

Reset
REQ-037 While rst_n=0, regardless of the clock, the block SHALL force state=IDLE, all m_* outputs=0, grant=00, both ack=0, both rdata=0, and pointer=port 1.
REQ-038 Reset asserted mid-BUSY SHALL abandon the transaction with no ack.
REQ-039 After reset, the block SHALL wait for m_config_done before the next grant.

Verification
REQ-040 Config gating: p0_req=1 with m_config_done=0 for 20 cycles, then 1 -> no m_bytesel activity before m_config_done, grant=01 on the first edge after.
REQ-041 Read: p0 reads addr 0x00000100 with bytesel=11; model returns 0xBEEF with m_compl 5 cycles later -> m_addr=0x00000100, m_wr_en=0, p0_rdata=0xBEEF, p0_ack pulses once, m_bytesel=00 the cycle after m_compl.
REQ-042 Round-robin: both ports request continuously for 4 transactions with FIXED_PRIO=0 -> grant order p0, p1, p0, p1; with FIXED_PRIO=1 -> p0 every time while p0_req=1.
REQ-043 Write and stray completion: p1 writes 0x1234 with bytesel=01, then m_compl is pulsed while IDLE -> m_wr_en=1 only during BUSY, exactly one p1_ack, no ack for the stray pulse.
REQ-044 Zero bytesel: p0_req=1 with bytesel=00 -> m_bytesel stays 00, p0_ack pulses 1 cycle after grant, p0_rdata unchanged.
REQ-045 Reset mid-operation: rst_n is pulsed low in BUSY -> all outputs are 0 immediately, no ack, and the next grant occurs only with m_config_done=1.
